// File: rtl/data_mem_arb_pkg.sv
// Shared types and sizes for the two-requester data memory arbiter.
package data_mem_arb_pkg;

  localparam int DEPTH  = 8;
  localparam int DEF_AW = $clog2(DEPTH);
  localparam int DEF_W  = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_ACCESS
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_W-1:0]  wdata;
    logic              id;
  } mem_req_t;

endpackage

// File: rtl/data_mem_arb_if.sv
// Request/response and memory-port bundle; slave is the arbiter's view, master the far side.
// DATA_MEM_ARB_LOCK_EN adds the per-requester req_lock bits.
interface data_mem_arb_if
  import data_mem_arb_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_we;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][W-1:0]  req_wdata;
  logic [1:0]         rsp_valid;
  logic [W-1:0]       rsp_rdata;
  logic [AW-1:0]      mem_address;
  logic [W-1:0]       mem_data_in;
  logic               mem_w_en;
  logic [W-1:0]       mem_data_out;
`ifdef DATA_MEM_ARB_LOCK_EN
  logic [1:0]         req_lock;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_lock, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, mem_address, mem_data_in, mem_w_en
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_lock, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, mem_address, mem_data_in, mem_w_en
  );
`else
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, mem_address, mem_data_in, mem_w_en
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, mem_address, mem_data_in, mem_w_en
  );
`endif
endinterface

// File: rtl/data_mem_arb_rr_pick2.sv
// Combinational 2-way round-robin picker: zero latency, one-hot grant; a held lock
// overrides the pointer only while both requesters are valid.
module rr_pick2 (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  input  logic       i_lock_vld,
  input  logic       i_lock_id,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11: begin
        if (i_lock_vld) o_grant = i_lock_id ? 2'b10 : 2'b01;
        else            o_grant = i_last    ? 2'b01 : 2'b10;
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_mem_arb.sv
// Round-robin arbiter/sequencer for the 8x8 data memory: accept at T, access at T+1, response at T+2;
// one transaction per 2 cycles, req_ready held low while busy. DATA_MEM_ARB_LOCK_EN enables grant locking.
module data_mem_arb
  import data_mem_arb_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_arb_if.slave bus
);

  arb_state_e   r_state;
  arb_state_e   w_state_nxt;
  mem_req_t     r_req;
  logic         r_last;
  logic [1:0]   r_rsp_valid;
  logic [W-1:0] r_rsp_rdata;
  logic [1:0]   w_grant;
  logic         w_win_id;
  logic         w_lock_vld;
  logic         w_lock_id;

`ifdef DATA_MEM_ARB_LOCK_EN
  logic r_lock_vld;
  logic r_lock_id;

  assign w_lock_vld = r_lock_vld;
  assign w_lock_id  = r_lock_id;
`else
  assign w_lock_vld = 1'b0;
  assign w_lock_id  = 1'b0;
`endif

  rr_pick2 u_pick (
    .i_valid    (bus.req_valid),
    .i_last     (r_last),
    .i_lock_vld (w_lock_vld),
    .i_lock_id  (w_lock_id),
    .o_grant    (w_grant)
  );

  assign w_win_id = w_grant[1];

  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = 2'b00;
    bus.mem_w_en  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        bus.req_ready = w_grant & {2{~rst}};
        if (|w_grant) w_state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        // A reset landing on the access cycle must not corrupt memory.
        bus.mem_w_en = r_req.we & ~rst;
        w_state_nxt  = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign bus.mem_address = r_req.addr;
  assign bus.mem_data_in = r_req.wdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_req       <= '0;
      r_last      <= 1'b1;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= 2'b00;
      if (r_state == ARB_IDLE && |w_grant) begin
        r_req.we    <= bus.req_we[w_win_id];
        r_req.addr  <= bus.req_addr[w_win_id];
        r_req.wdata <= bus.req_wdata[w_win_id];
        r_req.id    <= w_win_id;
        r_last      <= w_win_id;
      end
      if (r_state == ARB_ACCESS) begin
        r_rsp_valid[r_req.id] <= 1'b1;
        r_rsp_rdata           <= r_req.we ? r_req.wdata : bus.mem_data_out;
      end
    end
  end

`ifdef DATA_MEM_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_vld <= 1'b0;
      r_lock_id  <= 1'b0;
    end else if (r_state == ARB_IDLE) begin
      // Owner walking away in IDLE releases the lock; a later grant may re-establish it.
      if (r_lock_vld && !bus.req_valid[r_lock_id]) r_lock_vld <= 1'b0;
      if (|w_grant) begin
        if (bus.req_lock[w_win_id]) begin
          r_lock_vld <= 1'b1;
          r_lock_id  <= w_win_id;
        end else if (r_lock_id == w_win_id) begin
          r_lock_vld <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_arb.sv
// Directed bench for data_mem_arb with a behavioural 8x8 memory preloaded with mem[i] = i.
module tb_data_mem_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  logic [7:0] mem [0:7];
  int wen_cnt = 0;
  int tests_run = 0;
  int tests_failed = 0;

  data_mem_arb_if bus ();

  data_mem_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'(i);
    end else if (bus.mem_w_en) begin
      mem[bus.mem_address] <= bus.mem_data_in;
    end
  end

  always @(posedge clk) if (bus.mem_w_en) wen_cnt++;

  assign bus.mem_data_out = mem[bus.mem_address];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef DATA_MEM_ARB_LOCK_EN
    bus.req_lock  = 2'b00;
`endif
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    mem_init = 1'b1;
    bus.req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #2;
    tests_run++; if (bus.req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
    tests_run++; if (bus.rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); end
    tests_run++; if (bus.rsp_rdata !== 8'h00) begin tests_failed++; $display("FAIL reset_rsp_rdata: got %h want 00", bus.rsp_rdata); end
    tests_run++; if (bus.mem_w_en !== 1'b0) begin tests_failed++; $display("FAIL reset_w_en: got %b want 0", bus.mem_w_en); end
    tests_run++; if (bus.mem_address !== 3'd0) begin tests_failed++; $display("FAIL reset_address: got %0d want 0", bus.mem_address); end
    tests_run++; if (bus.mem_data_in !== 8'h00) begin tests_failed++; $display("FAIL reset_data_in: got %h want 00", bus.mem_data_in); end
    bus.req_valid = 2'b00;
    step();
    rst = 1'b0;
    mem_init = 1'b0;
  endtask

  task automatic test_single_read;
    int w0;
    w0 = wen_cnt;
    step();
    bus.req_valid = 2'b01; bus.req_we = 2'b00; bus.req_addr[0] = 3'd5;
    #1;
    tests_run++; if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL rd_ready_T: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    #1;
    tests_run++; if (bus.mem_address !== 3'd5) begin tests_failed++; $display("FAIL rd_address: got %0d want 5", bus.mem_address); end
    tests_run++; if (bus.rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL rd_rsp_early: got %b want 00", bus.rsp_valid); end
    step(); #1;
    tests_run++; if (bus.rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL rd_rsp_valid_T2: got %b want 01", bus.rsp_valid); end
    tests_run++; if (bus.rsp_rdata !== 8'h05) begin tests_failed++; $display("FAIL rd_rsp_rdata: got %h want 05", bus.rsp_rdata); end
    step(); #1;
    tests_run++; if (bus.rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL rd_rsp_one_cycle: got %b want 00", bus.rsp_valid); end
    tests_run++; if (wen_cnt !== w0) begin tests_failed++; $display("FAIL rd_no_write: got %0d writes want 0", wen_cnt - w0); end
  endtask

  task automatic test_write_read;
    step();
    bus.req_valid = 2'b10; bus.req_we = 2'b10; bus.req_addr[1] = 3'd3; bus.req_wdata[1] = 8'hA5;
    #1;
    tests_run++; if (bus.req_ready !== 2'b10) begin tests_failed++; $display("FAIL wr_ready: got %b want 10", bus.req_ready); end
    step();
    bus.req_we = 2'b00;
    #1;
    tests_run++; if (bus.req_ready !== 2'b00) begin tests_failed++; $display("FAIL wr_busy_ready: got %b want 00", bus.req_ready); end
    tests_run++; if (bus.mem_w_en !== 1'b1) begin tests_failed++; $display("FAIL wr_w_en: got %b want 1", bus.mem_w_en); end
    tests_run++; if (bus.mem_data_in !== 8'hA5) begin tests_failed++; $display("FAIL wr_data_in: got %h want a5", bus.mem_data_in); end
    tests_run++; if (bus.mem_address !== 3'd3) begin tests_failed++; $display("FAIL wr_address: got %0d want 3", bus.mem_address); end
    step(); #1;
    tests_run++; if (bus.rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL wr_ack_valid: got %b want 10", bus.rsp_valid); end
    tests_run++; if (bus.rsp_rdata !== 8'hA5) begin tests_failed++; $display("FAIL wr_ack_rdata: got %h want a5", bus.rsp_rdata); end
    tests_run++; if (bus.req_ready !== 2'b10) begin tests_failed++; $display("FAIL raw_ready: got %b want 10", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    #1;
    tests_run++; if (bus.mem_w_en !== 1'b0) begin tests_failed++; $display("FAIL raw_w_en: got %b want 0", bus.mem_w_en); end
    step(); #1;
    tests_run++; if (bus.rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL raw_rsp_valid: got %b want 10", bus.rsp_valid); end
    tests_run++; if (bus.rsp_rdata !== 8'hA5) begin tests_failed++; $display("FAIL raw_rdata: got %h want a5", bus.rsp_rdata); end
  endtask

  task automatic test_alternate;
    logic [1:0] exp_rdy;
    logic [1:0] prev_rdy;
    logic [7:0] prev_dat;
    step();
    bus.req_valid = 2'b11; bus.req_we = 2'b00;
    bus.req_addr[0] = 3'd1; bus.req_addr[1] = 3'd2;
    prev_rdy = 2'b00; prev_dat = 8'h00;
    for (int g = 0; g < 4; g++) begin
      exp_rdy = (g % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      tests_run++; if (bus.req_ready !== exp_rdy) begin tests_failed++; $display("FAIL alt_grant%0d: got %b want %b", g, bus.req_ready, exp_rdy); end
      if (g > 0) begin
        tests_run++; if (bus.rsp_valid !== prev_rdy || bus.rsp_rdata !== prev_dat) begin
          tests_failed++; $display("FAIL alt_rsp%0d: got %b/%h want %b/%h", g - 1, bus.rsp_valid, bus.rsp_rdata, prev_rdy, prev_dat);
        end
      end
      prev_rdy = exp_rdy;
      prev_dat = (g % 2 == 0) ? 8'h01 : 8'h02;
      step();
      if (g == 3) bus.req_valid = 2'b00;
      step();
    end
    #1;
    tests_run++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 8'h02) begin
      tests_failed++; $display("FAIL alt_rsp3: got %b/%h want 10/02", bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_reset_mid_write;
    step();
    bus.req_valid = 2'b01; bus.req_we = 2'b01; bus.req_addr[0] = 3'd7; bus.req_wdata[0] = 8'hFF;
    #1;
    tests_run++; if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL rstw_ready: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00; bus.req_we = 2'b00; rst = 1'b1;
    #1;
    tests_run++; if (bus.mem_w_en !== 1'b0) begin tests_failed++; $display("FAIL rstw_w_en: got %b want 0", bus.mem_w_en); end
    step();
    rst = 1'b0;
    #1;
    tests_run++; if (bus.rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL rstw_no_rsp: got %b want 00", bus.rsp_valid); end
    // Last grant was requester 0; only a reset pointer hands contention back to 0.
    bus.req_valid = 2'b11; bus.req_addr[0] = 3'd7; bus.req_addr[1] = 3'd6;
    #1;
    tests_run++; if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL rstw_ptr: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b10;
    step(); #1;
    tests_run++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'h07) begin
      tests_failed++; $display("FAIL rstw_addr7: got %b/%h want 01/07", bus.rsp_valid, bus.rsp_rdata);
    end
    tests_run++; if (bus.req_ready !== 2'b10) begin tests_failed++; $display("FAIL rstw_ready1: got %b want 10", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    step(); #1;
    tests_run++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 8'h06) begin
      tests_failed++; $display("FAIL rstw_addr6: got %b/%h want 10/06", bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_hold;
    int acc;
    int rsp;
    logic granted;
    acc = 0; rsp = 0; granted = 1'b0;
    bus.req_we = 2'b00;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.rsp_valid[0]) begin
        tests_run++; if (bus.rsp_rdata !== 8'(4 + rsp)) begin tests_failed++; $display("FAIL hold_rdata%0d: got %h want %h", rsp, bus.rsp_rdata, 8'(4 + rsp)); end
        rsp++;
      end
      if (acc == 3) bus.req_valid = 2'b00;
      else begin bus.req_valid = 2'b01; bus.req_addr[0] = 3'(4 + acc); end
      #1;
      if (granted) begin
        tests_run++; if (bus.mem_address !== 3'(3 + acc)) begin tests_failed++; $display("FAIL hold_sampled: got %0d want %0d", bus.mem_address, 3 + acc); end
      end
      granted = bus.req_ready[0];
      if (granted) acc++;
    end
    tests_run++; if (acc !== 3) begin tests_failed++; $display("FAIL hold_accepts: got %0d want 3", acc); end
    tests_run++; if (rsp !== 3) begin tests_failed++; $display("FAIL hold_responses: got %0d want 3", rsp); end
  endtask

`ifdef DATA_MEM_ARB_LOCK_EN
  task automatic test_lock;
    logic [3:0] grants;
    int n;
    int nreq0;
    clear_inputs();
    step(); rst = 1'b1;
    step(); rst = 0;
    grants = 4'b0000; n = 0; nreq0 = 0;
    bus.req_valid = 2'b11; bus.req_addr[0] = 3'd1; bus.req_addr[1] = 3'd2; bus.req_lock = 2'b01;
    for (int c = 0; c < 20 && n < 4; c++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        grants[n] = bus.req_ready[1];
        n++;
        if (bus.req_ready[0]) nreq0++;
      end
      step();
      if (nreq0 >= 3) bus.req_valid[0] = 1'b0;
      bus.req_lock[0] = (nreq0 < 2);
      if (n == 4) bus.req_valid = 2'b00;
    end
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL lock_grant_count: got %0d want 4", n); end
    tests_run++; if (grants !== 4'b1000) begin tests_failed++; $display("FAIL lock_sequence: got %b want 1000 (msb = 4th grant)", grants); end
    clear_inputs();
    repeat (3) step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_alternate();
    test_reset_mid_write();
    test_hold();
`ifdef DATA_MEM_ARB_LOCK_EN
    test_lock();
`endif
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
